// File: rtl/arashi_cache_ctrl_if.sv
// Requester and cache-array signal bundle for arashi_cache_ctrl.
// master = requesters plus cache array model, slave = controller.
interface arashi_cache_ctrl_if #(
  parameter int unsigned THREAD_NUM = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TID_W      = $clog2(THREAD_NUM)
);
  logic [THREAD_NUM-1:0]            req;
  logic [THREAD_NUM-1:0]            req_wr;
  logic [DATA_WIDTH*THREAD_NUM-1:0] req_data;
  logic [THREAD_NUM-1:0]            gnt;
  logic [THREAD_NUM-1:0]            w_ena;
  logic [THREAD_NUM-1:0]            r_ena;
  logic [DATA_WIDTH*THREAD_NUM-1:0] data_in;
  logic [DATA_WIDTH*THREAD_NUM-1:0] data_out;
  logic                             rsp_valid;
  logic [TID_W-1:0]                 rsp_id;
  logic [DATA_WIDTH-1:0]            rsp_data;

  modport master (
    output req, req_wr, req_data, data_out,
    input  gnt, w_ena, r_ena, data_in, rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  req, req_wr, req_data, data_out,
    output gnt, w_ena, r_ena, data_in, rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/arashi_cache_ctrl.sv
// Round-robin sequencer for the multi-thread cache array: one lane per transaction.
// Optional ARASHI_CACHE_CTRL_WR_PRIO_EN: writes win arbitration over reads.
module arashi_cache_ctrl #(
  parameter int unsigned THREAD_NUM = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TID_W      = $clog2(THREAD_NUM)
) (
  input logic               clk,
  input logic               rstn,
  arashi_cache_ctrl_if.slave bus
);
  localparam int unsigned BUS_W = DATA_WIDTH * THREAD_NUM;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPT, RESP} state_e;

  state_e                  state_q, state_d;
  logic [TID_W-1:0]        sel_q, sel_d;
  logic [TID_W-1:0]        last_q, last_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [TID_W-1:0]        rsp_id_q, rsp_id_d;
  logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic [THREAD_NUM-1:0]   arb_mask;
  logic [THREAD_NUM-1:0]   gnt_c, w_ena_c, r_ena_c;
  logic [BUS_W-1:0]        data_in_c;

  // First set bit of mask searching upward from last+1, wrapping.
  function automatic logic [TID_W-1:0] rr_pick(input logic [THREAD_NUM-1:0] mask,
                                               input logic [TID_W-1:0]      last);
    logic [TID_W-1:0] pick;
    logic             found;
    int unsigned      idx;
    pick  = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= THREAD_NUM; k++) begin
      idx = (32'(last) + k) % THREAD_NUM;
      if (!found && mask[idx]) begin
        pick  = TID_W'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

`ifdef ARASHI_CACHE_CTRL_WR_PRIO_EN
  assign arb_mask = (|(bus.req & bus.req_wr)) ? (bus.req & bus.req_wr) : bus.req;
`else
  assign arb_mask = bus.req;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      last_q      <= TID_W'(THREAD_NUM - 1);
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      last_q      <= last_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    last_d      = last_q;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    gnt_c       = '0;
    w_ena_c     = '0;
    r_ena_c     = '0;
    data_in_c   = '0;
    case (state_q)
      IDLE: begin
        if (|arb_mask) begin
          sel_d   = rr_pick(arb_mask, last_q);
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // A withdrawn request aborts without touching the pointer.
        if (!bus.req[sel_q]) begin
          state_d = IDLE;
        end else begin
          gnt_c[sel_q] = 1'b1;
          last_d       = sel_q;
          if (bus.req_wr[sel_q]) begin
            w_ena_c[sel_q] = 1'b1;
            data_in_c[32'(sel_q)*DATA_WIDTH +: DATA_WIDTH] =
              bus.req_data[32'(sel_q)*DATA_WIDTH +: DATA_WIDTH];
            state_d = IDLE;
          end else begin
            r_ena_c[sel_q] = 1'b1;
            state_d        = CAPT;
          end
        end
      end
      CAPT: begin
        rsp_data_d  = bus.data_out[32'(sel_q)*DATA_WIDTH +: DATA_WIDTH];
        rsp_id_d    = sel_q;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.gnt       = gnt_c;
  assign bus.w_ena     = w_ena_c;
  assign bus.r_ena     = r_ena_c;
  assign bus.data_in   = data_in_c;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
endmodule

// File: tb/tb_arashi_cache_ctrl.sv
// Self-checking bench for arashi_cache_ctrl: grant/response scoreboard plus per-scenario checks.
module tb_arashi_cache_ctrl;
  localparam int unsigned TN = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned TW = 2;

  typedef struct packed {
    logic [TW-1:0] tid;
    logic          wr;
    logic [DW-1:0] data;
  } gexp_t;

  typedef struct packed {
    logic [TW-1:0] tid;
    logic [DW-1:0] data;
  } rexp_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  arashi_cache_ctrl_if #(.THREAD_NUM(TN), .DATA_WIDTH(DW), .TID_W(TW)) bus ();

  arashi_cache_ctrl #(.THREAD_NUM(TN), .DATA_WIDTH(DW), .TID_W(TW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  gexp_t gq[$];
  rexp_t rq[$];
  logic [DW-1:0] rd_val [TN];

  // Cache array model: a lane's slice is only meaningful the cycle after its r_ena.
  always @(posedge clk)
    for (int i = 0; i < TN; i++)
      bus.data_out[i*DW +: DW] <= bus.r_ena[i] ? rd_val[i] : (32'hDEAD_0000 | 32'(i));

  gexp_t             m_e;
  rexp_t             m_r;
  logic [TN-1:0]     m_oh;
  logic [TN*DW-1:0]  m_din;

  // Scoreboard: every grant and every response must match the next expectation in order.
  always @(negedge clk) if (rstn) begin
    checks++;
    if ($countones({bus.w_ena, bus.r_ena}) > 1) begin
      errors++;
      $display("FAIL onehot_enables w_ena=%b r_ena=%b required at most one bit", bus.w_ena, bus.r_ena);
    end
    if (bus.gnt !== '0) begin
      checks++;
      if (gq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_gnt gnt=%b required none", bus.gnt);
      end else begin
        m_e   = gq.pop_front();
        m_oh  = TN'(1) << m_e.tid;
        m_din = m_e.wr ? ({{((TN-1)*DW){1'b0}}, m_e.data} << (32'(m_e.tid) * DW)) : '0;
        if (bus.gnt !== m_oh || bus.w_ena !== (m_e.wr ? m_oh : '0) ||
            bus.r_ena !== (m_e.wr ? '0 : m_oh) || bus.data_in !== m_din)
        begin
          errors++;
          $display("FAIL sb_gnt gnt=%b w=%b r=%b din=%h required gnt=%b wr=%b din=%h",
                   bus.gnt, bus.w_ena, bus.r_ena, bus.data_in, m_oh, m_e.wr, m_din);
        end
      end
    end else begin
      checks++;
      if (bus.w_ena !== '0 || bus.r_ena !== '0 || bus.data_in !== '0) begin
        errors++;
        $display("FAIL idle_outputs w=%b r=%b din=%h required all 0", bus.w_ena, bus.r_ena, bus.data_in);
      end
    end
    if (bus.rsp_valid === 1'b1) begin
      checks++;
      if (rq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rsp id=%0d data=%h required none", bus.rsp_id, bus.rsp_data);
      end else begin
        m_r = rq.pop_front();
        if (bus.rsp_id !== m_r.tid || bus.rsp_data !== m_r.data) begin
          errors++;
          $display("FAIL sb_rsp id=%0d data=%h required id=%0d data=%h",
                   bus.rsp_id, bus.rsp_data, m_r.tid, m_r.data);
        end
      end
    end
  end

  // Requesters hold req until granted, then drop it the cycle after gnt.
  task automatic run_reqs(input int budget);
    logic [TN-1:0] g;
    for (int c = 0; c < budget && bus.req != '0; c++) begin
      @(negedge clk);
      g = bus.gnt;
      @(posedge clk);
      #1;
      bus.req = bus.req & ~g;
    end
    bus.req = '0;
  endtask

  task automatic wait_empty(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (gq.size() == 0 && rq.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.gnt !== '0 || bus.w_ena !== '0 || bus.r_ena !== '0) begin
      errors++;
      $display("FAIL reset_enables gnt=%b w=%b r=%b required 0", bus.gnt, bus.w_ena, bus.r_ena);
    end
    checks++;
    if (bus.data_in !== '0) begin
      errors++;
      $display("FAIL reset_data_in got %h required 0", bus.data_in);
    end
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_id !== '0 || bus.rsp_data !== '0) begin
      errors++;
      $display("FAIL reset_rsp valid=%b id=%0d data=%h required 0", bus.rsp_valid, bus.rsp_id, bus.rsp_data);
    end
    rstn = 1'b1;
  endtask

  task automatic test_write();
    bit ok;
    gq.push_back('{tid: TW'(2), wr: 1'b1, data: 32'hA5A5_0001});
    @(posedge clk); #1;
    bus.req = 4'b0100; bus.req_wr = 4'b0100;
    bus.req_data[2*DW +: DW] = 32'hA5A5_0001;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.gnt !== 4'b0100 || bus.w_ena !== 4'b0100 || bus.r_ena !== 4'b0000) begin
      errors++;
      $display("FAIL write_lane gnt=%b w=%b r=%b required 0100 0100 0000", bus.gnt, bus.w_ena, bus.r_ena);
    end
    checks++;
    if (bus.data_in !== {32'h0, 32'hA5A5_0001, 32'h0, 32'h0}) begin
      errors++;
      $display("FAIL write_data_in got %h required slice2=a5a50001 others 0", bus.data_in);
    end
    @(posedge clk); #1;
    bus.req = '0;
    wait_empty(10, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL drain_write pending %0d/%0d required 0/0", gq.size(), rq.size());
      gq.delete(); rq.delete();
    end
  endtask

  task automatic test_read();
    bit ok;
    rd_val[1] = 32'h1234_5678;
    gq.push_back('{tid: TW'(1), wr: 1'b0, data: '0});
    rq.push_back('{tid: TW'(1), data: 32'h1234_5678});
    @(posedge clk); #1;
    bus.req = 4'b0010; bus.req_wr = 4'b0000;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.r_ena !== 4'b0010 || bus.gnt !== 4'b0010 || bus.w_ena !== 4'b0000) begin
      errors++;
      $display("FAIL read_issue gnt=%b r=%b w=%b required 0010 0010 0000", bus.gnt, bus.r_ena, bus.w_ena);
    end
    @(posedge clk); #1;
    bus.req = '0;
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL read_early_rsp valid=%b required 0 at capture cycle", bus.rsp_valid);
    end
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd1 || bus.rsp_data !== 32'h1234_5678) begin
      errors++;
      $display("FAIL read_rsp valid=%b id=%0d data=%h required 1 1 12345678",
               bus.rsp_valid, bus.rsp_id, bus.rsp_data);
    end
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL read_rsp_pulse valid=%b required 0 after one cycle", bus.rsp_valid);
    end
    wait_empty(10, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL drain_read pending %0d/%0d required 0/0", gq.size(), rq.size());
      gq.delete(); rq.delete();
    end
  endtask

  task automatic test_back_to_back();
    logic [TN-1:0] exp;
    bit ok;
    pulse_reset();
    for (int i = 0; i < 6; i++)
      gq.push_back('{tid: TW'(i % TN), wr: 1'b1, data: 32'hB000_0000 + 32'(i % TN)});
    @(posedge clk); #1;
    for (int i = 0; i < TN; i++) bus.req_data[i*DW +: DW] = 32'hB000_0000 + 32'(i);
    bus.req = 4'hF; bus.req_wr = 4'hF;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk);
      if (c == 12) begin #1; bus.req = '0; end
      @(negedge clk);
      exp = (c % 2 == 1) ? TN'(1) << ((c - 1) / 2 % TN) : '0;
      checks++;
      if (bus.gnt !== exp) begin
        errors++;
        $display("FAIL b2b_cycle%0d gnt=%b required %b", c, bus.gnt, exp);
      end
    end
    wait_empty(10, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL drain_b2b pending %0d/%0d required 0/0", gq.size(), rq.size());
      gq.delete(); rq.delete();
    end
  endtask

  task automatic test_withdraw();
    bit ok;
    @(posedge clk); #1;
    bus.req = 4'b1000; bus.req_wr = 4'b1000;
    @(posedge clk); #1;
    bus.req = '0;
    @(negedge clk);
    checks++;
    if (bus.gnt !== '0 || bus.w_ena !== '0 || bus.r_ena !== '0) begin
      errors++;
      $display("FAIL withdraw_abort gnt=%b w=%b r=%b required 0", bus.gnt, bus.w_ena, bus.r_ena);
    end
    // Pointer still at thread 1, so thread 2 must beat thread 0.
    gq.push_back('{tid: TW'(2), wr: 1'b1, data: 32'hB000_0002});
    gq.push_back('{tid: TW'(0), wr: 1'b1, data: 32'hB000_0000});
    @(posedge clk); #1;
    bus.req = 4'b0101; bus.req_wr = 4'b0101;
    run_reqs(20);
    wait_empty(10, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL drain_withdraw pending %0d/%0d required 0/0", gq.size(), rq.size());
      gq.delete(); rq.delete();
    end
  endtask

  task automatic test_reset_mid_read();
    bit ok;
    bit seen;
    rd_val[1] = 32'hCAFE_0001;
    gq.push_back('{tid: TW'(1), wr: 1'b0, data: '0});
    rq.push_back('{tid: TW'(1), data: 32'hCAFE_0001});
    @(posedge clk); #1;
    bus.req = 4'b0010; bus.req_wr = 4'b0000;
    run_reqs(10);
    wait_empty(10, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL drain_pre_read pending %0d/%0d required 0/0", gq.size(), rq.size());
      gq.delete(); rq.delete();
    end
    rd_val[2] = 32'hBEEF_0002;
    gq.push_back('{tid: TW'(2), wr: 1'b0, data: '0});
    @(posedge clk); #1;
    bus.req = 4'b0100;
    @(posedge clk);
    @(posedge clk); #1;
    bus.req = '0;
    @(negedge clk);
    rstn = 1'b0;
    #1;
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_id !== '0 || bus.rsp_data !== '0) begin
      errors++;
      $display("FAIL midread_rsp valid=%b id=%0d data=%h required 0", bus.rsp_valid, bus.rsp_id, bus.rsp_data);
    end
    checks++;
    if (bus.gnt !== '0 || bus.w_ena !== '0 || bus.r_ena !== '0 || bus.data_in !== '0) begin
      errors++;
      $display("FAIL midread_lanes gnt=%b w=%b r=%b din=%h required 0", bus.gnt, bus.w_ena, bus.r_ena, bus.data_in);
    end
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL midread_no_rsp saw rsp_valid required none");
    end
    // Pointer back at THREAD_NUM-1: thread 0 must beat thread 3.
    gq.push_back('{tid: TW'(0), wr: 1'b1, data: 32'h0000_00A0});
    gq.push_back('{tid: TW'(3), wr: 1'b1, data: 32'h0000_00A3});
    @(posedge clk); #1;
    bus.req_data[0*DW +: DW] = 32'h0000_00A0;
    bus.req_data[3*DW +: DW] = 32'h0000_00A3;
    bus.req = 4'b1001; bus.req_wr = 4'b1001;
    run_reqs(20);
    wait_empty(10, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL drain_post_reset pending %0d/%0d required 0/0", gq.size(), rq.size());
      gq.delete(); rq.delete();
    end
  endtask

  task automatic test_prio();
    bit ok;
    pulse_reset();
    rd_val[0] = 32'h0F0F_0000;
`ifdef ARASHI_CACHE_CTRL_WR_PRIO_EN
    gq.push_back('{tid: TW'(3), wr: 1'b1, data: 32'h3333_0003});
    gq.push_back('{tid: TW'(0), wr: 1'b0, data: '0});
`else
    gq.push_back('{tid: TW'(0), wr: 1'b0, data: '0});
    gq.push_back('{tid: TW'(3), wr: 1'b1, data: 32'h3333_0003});
`endif
    rq.push_back('{tid: TW'(0), data: 32'h0F0F_0000});
    @(posedge clk); #1;
    bus.req_data[3*DW +: DW] = 32'h3333_0003;
    bus.req = 4'b1001; bus.req_wr = 4'b1000;
    run_reqs(30);
    wait_empty(10, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL drain_prio pending %0d/%0d required 0/0", gq.size(), rq.size());
      gq.delete(); rq.delete();
    end
  endtask

  initial begin
    for (int i = 0; i < TN; i++) rd_val[i] = '0;
    bus.req      = '0;
    bus.req_wr   = '0;
    bus.req_data = '0;
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_withdraw();
    test_reset_mid_read();
    test_prio();
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout simulation exceeded 50000 time units");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end
endmodule
